// File: rtl/branch_pc_unit_pkg.sv
// Shared constants for the branch/PC stage: branch_op bit indices, A64
// condition codes, NZCV flag positions and the redirect FSM state type.
package branch_pc_unit_pkg;

  localparam int BRANCHCTRL_B     = 0;
  localparam int BRANCHCTRL_BR    = 1;
  localparam int BRANCHCTRL_BL    = 2;
  localparam int BRANCHCTRL_CBZ   = 3;
  localparam int BRANCHCTRL_CBNZ  = 4;
  localparam int BRANCHCTRL_BCOND = 5;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Flags are packed {N,Z,C,V}, MSB first.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } pc_state_e;

endpackage

// File: rtl/branch_pc_unit_if.sv
// Decode-side bundle into the branch/PC stage and its fetch-side results.
interface branch_pc_unit_if #(
  parameter int ADDR_W        = 64,
  parameter int BRANCHOP_SIZE = 6
);
  logic                     stall;
  logic                     in_valid;
  logic [ADDR_W-1:0]        br_pc;
  logic [BRANCHOP_SIZE-1:0] branch_op;
  logic [ADDR_W-1:0]        imm;
  logic [ADDR_W-1:0]        reg_data;
  logic [3:0]               cond;
  logic                     setflags;
  logic [3:0]               alu_flags;
  logic [ADDR_W-1:0]        fetch_pc;
  logic                     fetch_valid;
  logic                     flush;
  logic [ADDR_W-1:0]        link_addr;
  logic                     link_we;
  logic [3:0]               flags;
  logic                     op_err;

  modport master (
    output stall, in_valid, br_pc, branch_op, imm, reg_data, cond, setflags, alu_flags,
    input  fetch_pc, fetch_valid, flush, link_addr, link_we, flags, op_err
  );

  modport slave (
    input  stall, in_valid, br_pc, branch_op, imm, reg_data, cond, setflags, alu_flags,
    output fetch_pc, fetch_valid, flush, link_addr, link_we, flags, op_err
  );
endinterface

// File: rtl/branch_pc_unit_cond_eval.sv
// Combinational A64 condition-code evaluation against an NZCV flag vector.
module branch_pc_unit_cond_eval
  import branch_pc_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);
  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_HS: taken = c;
      COND_LO: taken = ~c;
      COND_MI: taken = n;
      COND_PL: taken = ~n;
      COND_VS: taken = v;
      COND_VC: taken = ~v;
      COND_HI: taken = c & ~z;
      COND_LS: taken = ~(c & ~z);
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = ~z & (n == v);
      COND_LE: taken = ~(~z & (n == v));
      default: taken = 1'b1;
    endcase
  end
endmodule

// File: rtl/branch_pc_unit.sv
// Branch resolution and architectural PC/NZCV ownership, with a single-cycle
// flush/redirect bubble toward fetch after every taken branch.
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter int                ADDR_W        = 64,
  parameter logic [ADDR_W-1:0] RESET_PC      = '0,
  parameter int                BRANCHOP_SIZE = 6
) (
  input logic              clk,
  input logic              reset,
  branch_pc_unit_if.slave  bus
);

  function automatic logic [ADDR_W-1:0] rel_target(
    input logic [ADDR_W-1:0]        pc,
    input logic signed [ADDR_W-1:0] word_off
  );
    logic signed [ADDR_W-1:0] byte_off;
    byte_off = word_off <<< 2;
    return pc + $unsigned(byte_off);
  endfunction

  pc_state_e                state_p1, state_d;
  logic [ADDR_W-1:0]        fetch_pc_p1, fetch_pc_d;
  logic                     vld_p1, vld_d;
  logic                     flush_p1, flush_d;
  logic [3:0]               flags_p1;
  logic                     op_err_p1;

  logic                     active_p0;
  logic                     op_onehot_p0;
  logic                     op_multi_p0;
  logic [BRANCHOP_SIZE-1:0] op_p0;
  logic signed [ADDR_W-1:0] imm_p0;
  logic                     rt_zero_p0;
  logic                     cond_taken_p0;
  logic                     taken_p0;
  logic [ADDR_W-1:0]        target_p0;

  // Stage p0: decode-side resolution; multi-hot ops collapse to "no branch".
  assign active_p0    = bus.in_valid & ~bus.stall & ~flush_p1;
  assign op_onehot_p0 = $onehot(bus.branch_op);
  assign op_multi_p0  = (bus.branch_op != '0) & ~op_onehot_p0;
  assign op_p0        = op_onehot_p0 ? bus.branch_op : '0;
  assign imm_p0       = bus.imm;
  assign rt_zero_p0   = (bus.reg_data == '0);

  branch_pc_unit_cond_eval u_cond_eval (
    .cond  (bus.cond),
    .flags (flags_p1),
    .taken (cond_taken_p0)
  );

  assign taken_p0 = op_p0[BRANCHCTRL_B] | op_p0[BRANCHCTRL_BL] | op_p0[BRANCHCTRL_BR]
                  | (op_p0[BRANCHCTRL_CBZ]   &  rt_zero_p0)
                  | (op_p0[BRANCHCTRL_CBNZ]  & ~rt_zero_p0)
                  | (op_p0[BRANCHCTRL_BCOND] &  cond_taken_p0);

  assign target_p0 = op_p0[BRANCHCTRL_BR] ? bus.reg_data : rel_target(bus.br_pc, imm_p0);

  assign bus.link_we   = active_p0 & op_p0[BRANCHCTRL_BL] & ~reset;
  assign bus.link_addr = bus.br_pc + ADDR_W'(4);

  always_comb begin
    state_d    = state_p1;
    fetch_pc_d = fetch_pc_p1;
    vld_d      = vld_p1;
    flush_d    = flush_p1;
    if (!bus.stall) begin
      case (state_p1)
        ST_RUN: begin
          if (active_p0 && taken_p0) begin
            fetch_pc_d = target_p0;
            flush_d    = 1'b1;
            vld_d      = 1'b0;
            state_d    = ST_REDIRECT;
          end else begin
            fetch_pc_d = fetch_pc_p1 + ADDR_W'(4);
          end
        end
        ST_REDIRECT: begin
          flush_d = 1'b0;
          vld_d   = 1'b1;
          state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Stage p1: architectural state; flags written after BCOND has read them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1    <= ST_RUN;
      fetch_pc_p1 <= RESET_PC;
      vld_p1      <= 1'b1;
      flush_p1    <= 1'b0;
      flags_p1    <= 4'b0000;
      op_err_p1   <= 1'b0;
    end else begin
      state_p1    <= state_d;
      fetch_pc_p1 <= fetch_pc_d;
      vld_p1      <= vld_d;
      flush_p1    <= flush_d;
      if (active_p0 && bus.setflags) flags_p1 <= bus.alu_flags;
      if (active_p0 && op_multi_p0)  op_err_p1 <= 1'b1;
    end
  end

  assign bus.fetch_pc    = fetch_pc_p1;
  assign bus.fetch_valid = vld_p1;
  assign bus.flush       = flush_p1;
  assign bus.flags       = flags_p1;
  assign bus.op_err      = op_err_p1;

endmodule
